// File: rtl/dma_pkg.sv
// Shared definitions for the host-DMA copy path: copy controller FSM states
// and the default transfer-length width also used by the DMAC instantiation.
package dma_pkg;

    localparam int DEFAULT_SIZE_WIDTH = 17;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        FLUSH,
        FIN
    } copy_state_e;

endpackage

// File: rtl/dma_copy_ctrl.sv
// Copy engine beside the DMAC: one go issues a read and a write DMA, moves words
// from the read FIFO to the write FIFO through a one-entry holding register.
module dma_copy_ctrl
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = DEFAULT_SIZE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  Rd_go,
    output logic                  Wr_go,
    output logic [SIZE_WIDTH-1:0] Rd_size,
    output logic [SIZE_WIDTH-1:0] Wr_size,
    output logic [ADDR_WIDTH-1:0] Rd_addr,
    output logic [ADDR_WIDTH-1:0] Wr_addr,
    input  logic [DATA_WIDTH-1:0] Rd_data,
    input  logic                  Empty,
    output logic                  Rd_en,
    input  logic                  Rd_done,
    output logic [DATA_WIDTH-1:0] Wr_data,
    input  logic                  Full,
    output logic                  Wr_en,
    input  logic                  Wr_done
);

    localparam logic [SIZE_WIDTH-1:0] CNT_ONE = SIZE_WIDTH'(1);

    copy_state_e           state_q;
    logic [ADDR_WIDTH-1:0] srcAddr_q;
    logic [ADDR_WIDTH-1:0] dstAddr_q;
    logic [SIZE_WIDTH-1:0] size_q;
    logic [SIZE_WIDTH-1:0] rdCnt_q;
    logic [SIZE_WIDTH-1:0] rdCnt_d;
    logic [SIZE_WIDTH-1:0] wrCnt_q;
    logic [SIZE_WIDTH-1:0] wrCnt_d;
    logic [DATA_WIDTH-1:0] holdData_q;
    logic [DATA_WIDTH-1:0] checksum_q;
    logic [DATA_WIDTH-1:0] checksum_d;
    logic                  holdValid_q;
    logic                  rdDoneSeen_q;
    logic                  wrDoneSeen_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  dmaGo_q;
    logic                  rdEn;
    logic                  wrEn;
    logic                  lastPush;
    logic                  active;

    // A pop is allowed only when the holding register is free or drains this cycle.
    always_comb begin
        wrEn       = (state_q == XFER) && holdValid_q && !Full;
        rdEn       = (state_q == XFER) && !Empty && (rdCnt_q < size_q)
                     && (!holdValid_q || wrEn);
        rdCnt_d    = rdCnt_q + CNT_ONE;
        wrCnt_d    = wrCnt_q + CNT_ONE;
        checksum_d = checksum_q + Rd_data;
        lastPush   = wrEn && (wrCnt_d == size_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            srcAddr_q    <= '0;
            dstAddr_q    <= '0;
            size_q       <= '0;
            rdCnt_q      <= '0;
            wrCnt_q      <= '0;
            holdData_q   <= '0;
            holdValid_q  <= 1'b0;
            checksum_q   <= '0;
            rdDoneSeen_q <= 1'b0;
            wrDoneSeen_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dmaGo_q      <= 1'b0;
        end else begin
            dmaGo_q <= 1'b0;
            done_q  <= 1'b0;

            // Completions may arrive before the last word moves, so they are kept sticky.
            if (state_q != IDLE) begin
                if (Rd_done) rdDoneSeen_q <= 1'b1;
                if (Wr_done) wrDoneSeen_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (go) begin
                        srcAddr_q    <= src_addr;
                        dstAddr_q    <= dst_addr;
                        size_q       <= size;
                        rdCnt_q      <= '0;
                        wrCnt_q      <= '0;
                        holdValid_q  <= 1'b0;
                        checksum_q   <= '0;
                        rdDoneSeen_q <= 1'b0;
                        wrDoneSeen_q <= 1'b0;
                        if (size != '0) begin
                            state_q <= START;
                            dmaGo_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                START: begin
                    state_q <= XFER;
                end
                XFER: begin
                    if (rdEn) begin
                        holdData_q  <= Rd_data;
                        holdValid_q <= 1'b1;
                        checksum_q  <= checksum_d;
                        rdCnt_q     <= rdCnt_d;
                    end else if (wrEn) begin
                        holdValid_q <= 1'b0;
                    end
                    if (wrEn) begin
                        wrCnt_q <= wrCnt_d;
                    end
                    if (lastPush) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (rdDoneSeen_q && wrDoneSeen_q) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign active   = (state_q != IDLE);
    assign Rd_addr  = active ? srcAddr_q : '0;
    assign Wr_addr  = active ? dstAddr_q : '0;
    assign Rd_size  = active ? size_q : '0;
    assign Wr_size  = active ? size_q : '0;
    assign Rd_go    = dmaGo_q;
    assign Wr_go    = dmaGo_q;
    assign Rd_en    = rdEn;
    assign Wr_en    = wrEn;
    assign Wr_data  = holdData_q;
    assign checksum = checksum_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Directed bench for dma_copy_ctrl: a behavioural first-word-fall-through read
// FIFO feeds the DUT and a posedge monitor logs every push, pop and done pulse.
module tb_dma_copy_ctrl;

    logic        clk;
    logic        rst;
    logic        go;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [16:0] size;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic        Rd_go;
    logic        Wr_go;
    logic [16:0] Rd_size;
    logic [16:0] Wr_size;
    logic [31:0] Rd_addr;
    logic [31:0] Wr_addr;
    logic [31:0] Rd_data;
    logic        Empty;
    logic        Rd_en;
    logic        Rd_done;
    logic [31:0] Wr_data;
    logic        Full;
    logic        Wr_en;
    logic        Wr_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] srcMem [16];
    int          popBase;
    int          fifoLen;
    int          fifoIdx;

    int          cyc = 0;
    int          popCount = 0;
    int          wrCount = 0;
    int          doneCount = 0;
    int          rdGoCount = 0;
    int          rdGoCyc = 0;
    int          wrDoneCyc = 0;
    int          doneCyc = 0;
    logic [31:0] doneChecksum = '0;
    logic        doneBusy = 1'b0;
    logic [31:0] wrLog [64];
    int          wrCyc [64];

    int wrBase;
    int doneBase;
    int goBase;

    dma_copy_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .SIZE_WIDTH(17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .size(size),
        .busy(busy),
        .done(done),
        .checksum(checksum),
        .Rd_go(Rd_go),
        .Wr_go(Wr_go),
        .Rd_size(Rd_size),
        .Wr_size(Wr_size),
        .Rd_addr(Rd_addr),
        .Wr_addr(Wr_addr),
        .Rd_data(Rd_data),
        .Empty(Empty),
        .Rd_en(Rd_en),
        .Rd_done(Rd_done),
        .Wr_data(Wr_data),
        .Full(Full),
        .Wr_en(Wr_en),
        .Wr_done(Wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read FIFO window: srcMem[0..fifoLen-1] counted from the pop number popBase.
    always_comb begin
        fifoIdx = popCount - popBase;
        Empty   = (fifoIdx >= fifoLen);
        Rd_data = Empty ? 32'h0 : srcMem[fifoIdx[3:0]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (Rd_en) popCount <= popCount + 1;
        if (Wr_en && wrCount < 64) begin
            wrLog[wrCount] <= Wr_data;
            wrCyc[wrCount] <= cyc;
            wrCount        <= wrCount + 1;
        end
        if (Rd_go) begin
            rdGoCount <= rdGoCount + 1;
            rdGoCyc   <= cyc;
        end
        if (Wr_done) wrDoneCyc <= cyc;
        if (done) begin
            doneCount    <= doneCount + 1;
            doneCyc      <= cyc;
            doneChecksum <= checksum;
            doneBusy     <= busy;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, 64'({busy, done, Rd_go, Wr_go, Rd_en, Wr_en}), 64'(0));
        checkOutput({tag, "_checksum"}, 64'(checksum), 64'(0));
        checkOutput({tag, "_wdata"}, 64'(Wr_data), 64'(0));
        checkOutput({tag, "_addr"}, {Rd_addr, Wr_addr}, 64'(0));
        checkOutput({tag, "_size"}, 64'({Rd_size, Wr_size}), 64'(0));
    endtask

    // Drives a one-cycle go; returns at the negedge of the cycle after go was sampled.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [16:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        size     = n;
        go       = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int target);
        int n = 0;
        while (doneCount < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(doneCount >= target), 64'(1));
    endtask

    task automatic waitWrites(input string tag, input int target);
        int n = 0;
        while (wrCount < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(wrCount >= target), 64'(1));
    endtask

    task automatic openWindow(input int len);
        popBase = popCount;
        fifoLen = len;
        wrBase  = wrCount;
        doneBase = doneCount;
        goBase  = rdGoCount;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst = 1'b1; go = 1'b0; src_addr = '0; dst_addr = '0; size = '0;
        Full = 1'b0; Rd_done = 1'b0; Wr_done = 1'b0;
        popBase = 0; fifoLen = 0;
        wrBase = 0; doneBase = 0; goBase = 0;
        for (int i = 0; i < 16; i++) srcMem[i] = '0;

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] four-word copy without stalls");
        for (int i = 0; i < 4; i++) srcMem[i] = 32'(i + 1);
        openWindow(4);
        applyStimulus(32'h100, 32'h200, 17'd4);
        Rd_done = 1'b1;
        Wr_done = 1'b1;
        checkOutput("t1_start_ctrl", 64'({Rd_go, Wr_go, busy, done}), 64'(4'b1110));
        checkOutput("t1_start_addr", {Rd_addr, Wr_addr}, {32'h100, 32'h200});
        checkOutput("t1_start_size", 64'({Rd_size, Wr_size}), 64'({17'd4, 17'd4}));
        waitDone("t1_done_timeout", doneBase + 1);
        Rd_done = 1'b0;
        Wr_done = 1'b0;
        checkOutput("t1_count", 64'(wrCount - wrBase), 64'(4));
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t1_word%0d", i), 64'(wrLog[wrBase + i]), 64'(i + 1));
        for (int i = 1; i < 4; i++)
            checkOutput($sformatf("t1_gap%0d", i), 64'(wrCyc[wrBase + i] - wrCyc[wrBase + i - 1]), 64'(1));
        checkOutput("t1_first_push", 64'(wrCyc[wrBase] - rdGoCyc), 64'(2));
        checkOutput("t1_done_lat", 64'(doneCyc - wrCyc[wrBase + 3]), 64'(2));
        checkOutput("t1_checksum", 64'(doneChecksum), 64'(10));
        checkOutput("t1_busy_at_done", 64'(doneBusy), 64'(0));
        @(negedge clk);
        checkOutput("t1_idle_outputs", 64'({Rd_addr, Rd_size, busy}), 64'(0));
        checkOutput("t1_checksum_held", 64'(checksum), 64'(10));

        $display("[TB] eight-word copy with five-cycle write stall");
        for (int i = 0; i < 10; i++) srcMem[i] = 32'hFFFF_FFF0 + 32'(i);
        openWindow(10);
        applyStimulus(32'h1000, 32'h2000, 17'd8);
        Rd_done = 1'b1;
        Wr_done = 1'b1;
        waitWrites("t2_prestall", wrBase + 3);
        Full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checkOutput($sformatf("t2_stall%0d", i), 64'({Rd_en, Wr_en}), 64'(0));
        end
        @(negedge clk);
        Full = 1'b0;
        waitDone("t2_done_timeout", doneBase + 1);
        Rd_done = 1'b0;
        Wr_done = 1'b0;
        checkOutput("t2_count", 64'(wrCount - wrBase), 64'(8));
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("t2_word%0d", i), 64'(wrLog[wrBase + i]), 64'(32'hFFFF_FFF0 + 32'(i)));
        checkOutput("t2_pops", 64'(popCount - popBase), 64'(8));
        checkOutput("t2_checksum", 64'(doneChecksum), 64'(32'hFFFF_FF9C));

        $display("[TB] zero-length copy");
        openWindow(0);
        applyStimulus(32'h55, 32'h66, 17'd0);
        checkOutput("t3_done_now", 64'({done, busy, Rd_go, Wr_go}), 64'(4'b1000));
        @(negedge clk);
        checkOutput("t3_after", 64'({done, busy}), 64'(0));
        checkOutput("t3_no_dma", 64'(rdGoCount - goBase), 64'(0));
        checkOutput("t3_checksum", 64'(checksum), 64'(0));

        $display("[TB] early read completion, late write completion");
        srcMem[0] = 32'd5; srcMem[1] = 32'd6; srcMem[2] = 32'd7;
        openWindow(3);
        applyStimulus(32'h40, 32'h80, 17'd3);
        Rd_done = 1'b1;
        @(negedge clk);
        Rd_done = 1'b0;
        waitWrites("t4_writes", wrBase + 3);
        @(negedge clk);
        checkOutput("t4_waiting", 64'({busy, done}), 64'(2'b10));
        @(negedge clk);
        Wr_done = 1'b1;
        @(negedge clk);
        Wr_done = 1'b0;
        waitDone("t4_done_timeout", doneBase + 1);
        checkOutput("t4_done_lat", 64'(doneCyc - wrDoneCyc), 64'(2));
        checkOutput("t4_checksum", 64'(doneChecksum), 64'(18));

        $display("[TB] reset during a sixteen-word copy");
        for (int i = 0; i < 16; i++) srcMem[i] = 32'h100 + 32'(i);
        openWindow(16);
        applyStimulus(32'h10, 32'h20, 17'd16);
        Rd_done = 1'b1;
        Wr_done = 1'b1;
        waitWrites("t5_prereset", wrBase + 5);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("t5_midreset");
        rst = 1'b0;
        Rd_done = 1'b0;
        Wr_done = 1'b0;
        srcMem[0] = 32'h1234_0000;
        srcMem[1] = 32'h0000_4321;
        openWindow(2);
        applyStimulus(32'h30, 32'h40, 17'd2);
        Rd_done = 1'b1;
        Wr_done = 1'b1;
        waitDone("t5_done_timeout", doneBase + 1);
        Rd_done = 1'b0;
        Wr_done = 1'b0;
        checkOutput("t5_count", 64'(wrCount - wrBase), 64'(2));
        checkOutput("t5_word0", 64'(wrLog[wrBase]), 64'(32'h1234_0000));
        checkOutput("t5_word1", 64'(wrLog[wrBase + 1]), 64'(32'h0000_4321));
        checkOutput("t5_checksum", 64'(doneChecksum), 64'(32'h1234_4321));

        $display("[TB] go re-asserted while busy");
        for (int i = 0; i < 5; i++) srcMem[i] = 32'hA + 32'(i);
        openWindow(5);
        applyStimulus(32'h300, 32'h400, 17'd3);
        Rd_done = 1'b1;
        Wr_done = 1'b1;
        src_addr = 32'h999;
        dst_addr = 32'h888;
        size     = 17'd5;
        go       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        go = 1'b0;
        checkOutput("t6_addr", {Rd_addr, Wr_addr}, {32'h300, 32'h400});
        checkOutput("t6_size", 64'({Rd_size, Wr_size}), 64'({17'd3, 17'd3}));
        waitDone("t6_done_timeout", doneBase + 1);
        Rd_done = 1'b0;
        Wr_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6_count", 64'(wrCount - wrBase), 64'(3));
        checkOutput("t6_pops", 64'(popCount - popBase), 64'(3));
        checkOutput("t6_one_dma", 64'(rdGoCount - goBase), 64'(1));
        checkOutput("t6_one_done", 64'(doneCount - doneBase), 64'(1));
        checkOutput("t6_checksum", 64'(doneChecksum), 64'(32'h21));
        checkOutput("t6_idle", 64'({busy, done}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_copy_ctrl.md
# dma_copy_ctrl

AFU-side copy engine sitting directly upstream of the DMAC host-DMA wrapper. On a single `go` it issues one read and one write DMA request of equal length, drains words from the DMAC read FIFO into the DMAC write FIFO through a one-entry holding register, and accumulates a running checksum. It pulses `done` once both DMA directions report completion.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 32: DMA address width. Offsets are relative; DMAC adds the base.
- `SIZE_WIDTH`, 17: word-count width.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `go` in 1: start pulse, sampled only in IDLE.
- `src_addr` in ADDR_WIDTH: read offset.
- `dst_addr` in ADDR_WIDTH: write offset.
- `size` in SIZE_WIDTH: number of words to copy.
- `busy` out 1: high from the cycle after an accepted `go` until `done`.
- `done` out 1: one-cycle completion pulse.
- `checksum` out DATA_WIDTH: sum of all words read, modulo 2^DATA_WIDTH. Valid when `done` is high. Held until the next `go`.
- `Rd_go`, `Wr_go` out 1: one-cycle request pulses to DMAC.
- `Rd_size`, `Wr_size` out SIZE_WIDTH: transfer length to DMAC.
- `Rd_addr`, `Wr_addr` out ADDR_WIDTH: offsets to DMAC.
- `Rd_data` in DATA_WIDTH: read-FIFO head word. First-word-fall-through: valid whenever `Empty`=0.
- `Empty` in 1: read FIFO empty.
- `Rd_en` out 1: pop the read FIFO.
- `Rd_done` in 1: read DMA complete, level or pulse.
- `Wr_data` out DATA_WIDTH: word to push.
- `Full` in 1: write FIFO full.
- `Wr_en` out 1: push the write FIFO.
- `Wr_done` in 1: write DMA complete, level or pulse.

## Operation
- FSM states: IDLE, START, XFER, FLUSH, FIN.
- IDLE:
  - `go`=1 registers `src_addr`, `dst_addr`, `size` and clears the counters, flags and `checksum`.
  - If `size`≠0, go to START. If `size`=0, go to FIN; no DMA is issued.
- START:
  - Assert `Rd_go` and `Wr_go` for exactly one cycle, then go to XFER.
  - `Rd_addr`/`Wr_addr`/`Rd_size`/`Wr_size` reflect the registered values from START until return to IDLE. They are 0 in IDLE.
- XFER:
  - `Rd_en` = `!Empty && rd_cnt<size && (!hold_valid || Wr_en)`.
  - `Wr_en` = `hold_valid && !Full`. `Wr_data` = `hold_data`.
  - On `Rd_en`: load `hold_data`←`Rd_data`, add `Rd_data` to `checksum`, and increment `rd_cnt`.
  - On `Wr_en` without `Rd_en`: clear `hold_valid`.
  - On `Wr_en`: increment `wr_cnt`.
  - When `wr_cnt` reaches `size`, go to FLUSH.
- FLUSH: wait until both sticky flags `rd_done_seen` and `wr_done_seen` are set, then go to FIN.
  - The flags are set by `Rd_done`/`Wr_done` in any non-IDLE state, so a completion arriving early is never lost.
- FIN: `done`=1 for one cycle, then go to IDLE.
- `go` outside IDLE is ignored.
- If the read FIFO delivers more than `size` words, they are not popped.
- Counters are SIZE_WIDTH wide. The maximum `size` is 2^SIZE_WIDTH−1, so no wrap occurs.
- Reset mid-operation: immediate return to IDLE with all state cleared. The DMA in flight is not aborted; the DMAC must be reset alongside this block.

## Timing
- Reset values: every output is 0, including `checksum`, `busy`, `done`, `Rd_en`, `Wr_en`, and all address and size outputs.
- `go` at cycle t → START at t+1 (`Rd_go`=`Wr_go`=1, `busy`=1) → XFER at t+2.
- Read-to-write latency is 1 cycle: a word popped at cycle n is pushed no earlier than n+1.
- Sustained throughput is 1 word/cycle when `Empty`=0 and `Full`=0.
- `Full` stalls writes; `Rd_en` then deasserts while `hold_valid`=1. Backpressure never drops or duplicates a word.
- Last push at cycle n, both done flags already set → FLUSH at n+1, FIN (`done`) at n+2, IDLE at n+3. `busy` falls with `done`.
- `size`=0: `go` at t → `done` at t+1, `busy` stays 0.

## Structure
- Shared package `dma_pkg`:
  - the FSM state enum `copy_state_e`;
  - the default `SIZE_WIDTH` constant, shared with the DMAC instantiation.
- No sub-module is required. The holding register is inline; a one-deep skid buffer is not worth a separate module.
- The top level instantiates `dma_copy_ctrl` next to `DMAC` and connects the DMAC-side ports by name.

## Test plan
- `size`=4, `src`=0x100, `dst`=0x200, read words 1,2,3,4, never full/empty stalls → `Wr_data` sequence 1,2,3,4 on consecutive cycles; `checksum`=10; `done` 2 cycles after the last push once both done signals are high.
- `size`=8 with `Full` held high for 5 cycles mid-transfer → no lost or duplicated words; `Rd_en` stays low while the holding register is occupied.
- `size`=0 → `done` the cycle after `go`; `Rd_go`/`Wr_go` never asserted.
- `Rd_done` pulsed before the final write, `Wr_done` pulsed 3 cycles after it → `done` exactly 2 cycles after `Wr_done`.
- `rst` asserted in the middle of a 16-word copy, then `go` with `size`=2 → all outputs 0 the cycle after reset; the new copy completes with the correct `checksum`.
- `go` re-asserted while `busy` → ignored; the original transfer's register values are unchanged.
